// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage
// Decode-to-execute pipeline stage. It decodes ALUOp/funct into the 4-bit ALU
// operation code, selects the second operand, and registers the result across
// the ID/EX boundary with stall, flush and bubble handling. A saturating
// counter records accepted instructions that carry an unsupported R-type funct.
//
// Ports:
//   clk, reset           - clock; synchronous active-high reset
//   stall, flush         - hold ID/EX contents / load a bubble (flush wins)
//   id_valid             - ID stage holds a real instruction
//   id_aluop, id_funct   - main-control ALUOp and instruction bits [5:0]
//   id_alusrc            - 1 selects id_imm as the second operand
//   id_rs_data/rt_data   - register-file read data
//   id_imm               - sign-extended immediate
//   ex_valid             - EX holds a real instruction
//   ex_alucontrol        - ALU operation code
//   ex_in1, ex_in2       - ALU operands
//   ex_illegal           - EX instruction had an unsupported funct
//   illegal_cnt          - saturating count of accepted illegal instructions
module alu_ctrl_stage #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [1:0]       id_aluop,
    input  logic [5:0]       id_funct,
    input  logic             id_alusrc,
    input  logic [31:0]      id_rs_data,
    input  logic [31:0]      id_rt_data,
    input  logic [31:0]      id_imm,
    output logic             ex_valid,
    output logic [3:0]       ex_alucontrol,
    output logic [31:0]      ex_in1,
    output logic [31:0]      ex_in2,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111
    } alu_op_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    alu_op_e     dec_code;
    logic        dec_illegal;
    logic [31:0] sel_in2;
    logic        load_real;

    always_comb begin
        dec_code    = ALU_ADD;
        dec_illegal = 1'b0;
        unique case (id_aluop)
            2'b00: dec_code = ALU_ADD;
            2'b01: dec_code = ALU_SUB;
            2'b11: dec_code = ALU_AND;
            2'b10: begin
                case (id_funct)
                    6'b100000: dec_code = ALU_ADD;
                    6'b100010: dec_code = ALU_SUB;
                    6'b100100: dec_code = ALU_AND;
                    6'b100101: dec_code = ALU_OR;
                    6'b101010: dec_code = ALU_SLT;
                    default: begin
                        dec_code    = ALU_AND;
                        dec_illegal = 1'b1;
                    end
                endcase
            end
            default: dec_code = ALU_ADD;
        endcase
    end

    assign sel_in2   = id_alusrc ? id_imm : id_rt_data;
    // A real load is the only path that can count an illegal instruction.
    assign load_real = !flush && !stall && id_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_alucontrol <= '0;
            ex_in1        <= '0;
            ex_in2        <= '0;
            ex_illegal    <= 1'b0;
            illegal_cnt   <= '0;
        end else begin
            if (flush || (!stall && !id_valid)) begin
                ex_valid      <= 1'b0;
                ex_alucontrol <= '0;
                ex_in1        <= '0;
                ex_in2        <= '0;
                ex_illegal    <= 1'b0;
            end else if (!stall) begin
                ex_valid      <= 1'b1;
                ex_alucontrol <= dec_code;
                ex_in1        <= id_rs_data;
                ex_in2        <= sel_in2;
                ex_illegal    <= dec_illegal;
            end
            if (load_real && dec_illegal && (illegal_cnt != CNT_MAX))
                illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

endmodule
